// File: rtl/onehot_stream_demux.sv
// rtl/onehot_stream_demux.sv - one-hot routed valid/ready demux with per-lane one-entry buffers
// Illegal (zero or multi-hot) selects are consumed, dropped and counted.
module onehot_stream_demux #(
  parameter type T         = logic,
  parameter int  SEL_WIDTH = 4,
  parameter int  CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  T                     in_data,
  input  logic [SEL_WIDTH-1:0] in_sel_oh,
  output logic [SEL_WIDTH-1:0] out_valid,
  input  logic [SEL_WIDTH-1:0] out_ready,
  output T                     out_data [SEL_WIDTH-1:0],
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 err_multihot
);

  logic [SEL_WIDTH-1:0] r_lane_vld;
  T                     r_lane_dat [SEL_WIDTH-1:0];
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic                 r_err_multihot;

  logic [SEL_WIDTH-1:0] w_lane_free;
  logic [SEL_WIDTH-1:0] w_push;
  logic [SEL_WIDTH-1:0] w_pop;
  logic                 w_sel_zero;
  logic                 w_sel_onehot;
  logic                 w_accept;
  logic                 w_drop;

  assign w_sel_zero   = (in_sel_oh == '0);
  assign w_sel_onehot = !w_sel_zero && ((in_sel_oh & (in_sel_oh - SEL_WIDTH'(1))) == '0);
  assign w_lane_free  = ~r_lane_vld | out_ready;

  // Illegal selects are always consumed so they can never stall the input.
  assign in_ready = w_sel_onehot ? |(in_sel_oh & w_lane_free) : 1'b1;
  assign w_accept = in_valid & in_ready;
  assign w_push   = (w_accept && w_sel_onehot) ? in_sel_oh : '0;
  assign w_pop    = r_lane_vld & out_ready;
  assign w_drop   = w_accept & ~w_sel_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_vld <= '0;
      for (int i = 0; i < SEL_WIDTH; i++) begin
        r_lane_dat[i] <= '0;
      end
    end else begin
      r_lane_vld <= (r_lane_vld & ~w_pop) | w_push;
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (w_push[i]) begin
          r_lane_dat[i] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt     <= '0;
      r_err_multihot <= 1'b0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
      if (w_accept && !w_sel_zero && !w_sel_onehot) begin
        r_err_multihot <= 1'b1;
      end
    end
  end

  assign out_valid    = r_lane_vld;
  assign out_data     = r_lane_dat;
  assign drop_cnt     = r_drop_cnt;
  assign err_multihot = r_err_multihot;

`ifdef COMM_ASSERT
  for (genvar g = 0; g < SEL_WIDTH; g++) begin : g_stable
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid[g] && !out_ready[g]) |=> (out_valid[g] && (out_data[g] == $past(out_data[g]))));
  end
`endif

endmodule
